// File: rtl/mem_stream_reader_if.sv
// Bundles the control, memory-port and GPIO signals of mem_stream_reader.
//   master : host/board side (drives start, abort, baseAddr, wordCount,
//            memData from the RAM, gpioIn from the external board)
//   slave  : the reader itself (drives memAddr, gpioOut, busy, done, error)
interface mem_stream_reader_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] wordCount;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [35:0]       gpioIn;
  logic [35:0]       gpioOut;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, baseAddr, wordCount, memData, gpioIn,
    input  memAddr, gpioOut, busy, done, error
  );

  modport slave (
    input  start, abort, baseAddr, wordCount, memData, gpioIn,
    output memAddr, gpioOut, busy, done, error
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Streams a block of memory words out over GPIO with a four-phase req/ack
// handshake. Reads the main memory through its read-only port b.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : mem_stream_reader_if.slave
//          start/abort/baseAddr/wordCount  transfer control
//          memAddr/memData                 RAM port b (1-cycle read latency)
//          gpioIn[0]                       ack from external board
//          gpioOut                         [23:0] data, [24] req, [25] last,
//                                          [26] active, [35:27] zero
//          busy/done/error                 status
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_FETCH   | memAddr stable, RAM samples it at the end of this cycle
// S_CAPTURE | RAM data valid; latch it, raise req
// S_REQ     | req high, waiting for synchronized ack high
// S_RELEASE | req low, waiting for synchronized ack low
module mem_stream_reader #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input logic                 clk,
  input logic                 rst,
  mem_stream_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_REQ,
    S_RELEASE
  } state_t;

  // Timeout runs as a down-counter loaded with TIMEOUT-1; reaching zero while
  // still waiting means TIMEOUT cycles have been spent in the wait state.
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic ack_s;
  logic busy;
  logic last_word;
  logic unused_gpio;

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign last_word   = (remaining_q == ADDR_W'(1));
  assign unused_gpio = ^bus.gpioIn[35:1];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tmr_q       <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      last_q      <= last_d;
      req_q       <= req_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tmr_q       <= tmr_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.gpioIn[0]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    last_d      = last_q;
    req_d       = req_q;
    done_d      = 1'b0;
    error_d     = error_q;
    tmr_d       = tmr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          error_d = 1'b0;
          if (bus.wordCount != '0) begin
            mem_addr_d  = bus.baseAddr;
            remaining_d = bus.wordCount;
            state_d     = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = bus.memData;
        last_d  = last_word;
        req_d   = 1'b1;
        tmr_d   = TMR_LOAD;
        state_d = S_REQ;
      end
      S_REQ: begin
        // An ack already high on entry counts as a valid ack; a stuck ack is
        // then caught by the RELEASE timeout.
        if (ack_s) begin
          req_d   = 1'b0;
          tmr_d   = TMR_LOAD;
          state_d = S_RELEASE;
        end else if (tmr_q == '0) begin
          error_d = 1'b1;
          req_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          if (last_word) begin
            done_d  = 1'b1;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            remaining_d = remaining_q - ADDR_W'(1);
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            state_d     = S_FETCH;
          end
        end else if (tmr_q == '0) begin
          error_d = 1'b1;
          req_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides everything decided above
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      mem_addr_d  = mem_addr_q;
      remaining_d = remaining_q;
      req_d       = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = error_q;
    end
  end

  // Outputs
  always_comb begin
    busy                = (state_q != S_IDLE);
    bus.gpioOut         = '0;
    bus.gpioOut[23:0]   = data_q[23:0];
    bus.gpioOut[24]     = req_q;
    bus.gpioOut[25]     = last_q;
    bus.gpioOut[26]     = busy;
  end

  assign bus.memAddr = mem_addr_q;
  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;
  localparam int AW = 18;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  bit bfm_en      = 1'b1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t expq[$];

  logic [DW-1:0] mem [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.a = a; e.d = d; e.l = l;
    expq.push_back(e);
  endtask

  // Synchronous-read RAM model
  always @(posedge clk)
    bus.memData <= mem.exists(int'(bus.memAddr)) ? mem[int'(bus.memAddr)] : '0;

  // External board: ack 2 cycles after req, hold ack 3 cycles after req drops
  initial begin
    bus.gpioIn = '0;
    forever begin
      @(negedge clk);
      if (bfm_en && bus.gpioOut[24] && !bus.gpioIn[0]) begin
        repeat (2) @(negedge clk);
        bus.gpioIn[0] = 1'b1;
        for (int i = 0; i < 64 && bus.gpioOut[24]; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        bus.gpioIn[0] = 1'b0;
      end
    end
  end

  // Monitor: every rising req must match the next expected word
  initial begin
    logic req_prev;
    exp_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.gpioOut[24] && !req_prev) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: req rose with data %0h, no word expected",
                     bus.gpioOut[23:0]);
          end else begin
            e = expq.pop_front();
            check("word_addr", 64'(bus.memAddr), 64'(e.a));
            check("word_data", 64'(bus.gpioOut[23:0]), 64'(e.d));
            check("word_last", 64'(bus.gpioOut[25]), 64'(e.l));
          end
        end
        if (bus.done) done_seen++;
        req_prev = bus.gpioOut[24];
      end else begin
        req_prev = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] count);
    @(posedge clk); #1;
    bus.baseAddr  = base;
    bus.wordCount = count;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic wait_req(input logic level, input int max);
    int n = 0;
    while (bus.gpioOut[24] !== level && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_req_level", 64'(bus.gpioOut[24]), 64'(level));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.baseAddr = '0;
    bus.wordCount = '0;
    mem[32'h10]    = 24'hABCDEF;
    mem[32'h3FFFE] = 24'h111111;
    mem[32'h3FFFF] = 24'h222222;
    mem[32'h00000] = 24'h333333;
    mem[32'h20]    = 24'h0F0F0F;
    mem[32'h21]    = 24'h123456;
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = 24'hA00000 + 24'(i);
    mem[32'h50]    = 24'h777777;
    mem[32'h100]   = 24'h5A5A5A;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_gpio", 64'(bus.gpioOut), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_addr", 64'(bus.memAddr), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_error", 64'(bus.error), 64'(0));
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    check("post_rst_gpio", 64'(bus.gpioOut), 64'(0));

    // Single word, exact latency
    push_exp(18'h10, 24'hABCDEF, 1'b1);
    d0 = done_seen;
    do_start(18'h10, 18'd1);
    check("single_addr_t1", 64'(bus.memAddr), 64'h10);
    @(posedge clk); #1;
    check("single_req_t2", 64'(bus.gpioOut[24]), 64'(0));
    @(posedge clk); #1;
    check("single_req_t3", 64'(bus.gpioOut[24]), 64'(1));
    check("single_data_t3", 64'(bus.gpioOut[23:0]), 64'hABCDEF);
    check("single_last_t3", 64'(bus.gpioOut[25]), 64'(1));
    wait_idle("single", 100);
    repeat (2) @(posedge clk); #1;
    check("single_done_cnt", 64'(done_seen - d0), 64'(1));
    check("single_hold_data", 64'(bus.gpioOut[23:0]), 64'hABCDEF);
    check("single_ctl_low", 64'(bus.gpioOut[26:24]), 64'(0));
    check("single_error", 64'(bus.error), 64'(0));

    // Burst across the address wrap
    push_exp(18'h3FFFE, 24'h111111, 1'b0);
    push_exp(18'h3FFFF, 24'h222222, 1'b0);
    push_exp(18'h00000, 24'h333333, 1'b1);
    d0 = done_seen;
    do_start(18'h3FFFE, 18'd3);
    wait_idle("burst", 300);
    repeat (2) @(posedge clk); #1;
    check("burst_done_cnt", 64'(done_seen - d0), 64'(1));
    check("burst_queue", 64'(expq.size()), 64'(0));

    // Zero count
    d0 = done_seen;
    do_start(18'h55, 18'd0);
    check("zero_done", 64'(bus.done), 64'(1));
    check("zero_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    check("zero_done_drop", 64'(bus.done), 64'(0));
    check("zero_busy2", 64'(bus.busy), 64'(0));
    repeat (4) @(posedge clk); #1;
    check("zero_done_cnt", 64'(done_seen - d0), 64'(1));

    // Timeout in REQ: req high for exactly 16 cycles
    bfm_en = 1'b0;
    push_exp(18'h20, 24'h0F0F0F, 1'b1);
    d0 = done_seen;
    do_start(18'h20, 18'd1);
    repeat (2) @(posedge clk); #1;
    check("to_req_first", 64'(bus.gpioOut[24]), 64'(1));
    repeat (15) @(posedge clk); #1;
    check("to_req_last", 64'(bus.gpioOut[24]), 64'(1));
    check("to_err_early", 64'(bus.error), 64'(0));
    @(posedge clk); #1;
    check("to_req_drop", 64'(bus.gpioOut[24]), 64'(0));
    check("to_error", 64'(bus.error), 64'(1));
    check("to_busy", 64'(bus.busy), 64'(0));
    repeat (3) @(posedge clk); #1;
    check("to_no_done", 64'(done_seen - d0), 64'(0));
    bfm_en = 1'b1;
    push_exp(18'h21, 24'h123456, 1'b1);
    d0 = done_seen;
    do_start(18'h21, 18'd1);
    check("to_err_clear", 64'(bus.error), 64'(0));
    wait_idle("to_next", 100);
    repeat (2) @(posedge clk); #1;
    check("to_next_done", 64'(done_seen - d0), 64'(1));

    // Abort during RELEASE of word 2 of 4
    push_exp(18'h40, 24'hA00000, 1'b0);
    push_exp(18'h41, 24'hA00001, 1'b0);
    d0 = done_seen;
    do_start(18'h40, 18'd4);
    wait_req(1'b1, 50);
    wait_req(1'b0, 50);
    wait_req(1'b1, 50);
    wait_req(1'b0, 50);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_ctl", 64'(bus.gpioOut[26:24]), 64'(0));
    check("abort_error", 64'(bus.error), 64'(0));
    repeat (10) @(posedge clk); #1;
    check("abort_no_done", 64'(done_seen - d0), 64'(0));
    check("abort_queue", 64'(expq.size()), 64'(0));
    push_exp(18'h50, 24'h777777, 1'b1);
    d0 = done_seen;
    do_start(18'h50, 18'd1);
    wait_idle("abort_next", 100);
    repeat (2) @(posedge clk); #1;
    check("abort_next_done", 64'(done_seen - d0), 64'(1));

    // Reset mid-burst: req drops asynchronously
    push_exp(18'h100, 24'h5A5A5A, 1'b0);
    do_start(18'h100, 18'd4);
    wait_req(1'b1, 50);
    rst = 1'b0;
    #1;
    check("midrst_gpio", 64'(bus.gpioOut), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_addr", 64'(bus.memAddr), 64'(0));
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("midrst_idle", 64'(bus.busy), 64'(0));
    check("midrst_req", 64'(bus.gpioOut[24]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side initiator on the main memory's read-only port b (address2/qb); streams a block of 24-bit words out to an external board over the 36-bit GPIO output.
- Uses a four-phase req/ack handshake on the GPIO pins; ack returns on the GPIO input.
- Lets processed data written by the CPU through port a be pulled off-chip without stalling the core.

Parameters:
ADDR_W, 18, main memory word-address width
DATA_W, 24, memory word width
SYNC_STAGES, 2, flops in the ack synchronizer (min 2)
TIMEOUT, 1000000, max cycles spent waiting on any ack edge before error

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse; begins a transfer when idle
abort  input  1  level; cancels the transfer in progress
baseAddr  input  ADDR_W  first word address, sampled on accepted start
wordCount  input  ADDR_W  number of words, sampled on accepted start
memAddr  output  ADDR_W  registered address to mainMemory address_b
memData  input  DATA_W  mainMemory q_b; synchronous read, 1-cycle latency
gpioIn  input  36  bit0 = ack from external board; bits 35:1 ignored
gpioOut  output  36  [23:0] data, [24] req, [25] last, [26] active, [35:27] 0
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky timeout flag; cleared on next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; memAddr=0; gpioOut=0; busy=0; done=0; error=0; remaining=0; synchronizer flops=0.
- ackS: gpioIn[0] through SYNC_STAGES flops. All handshake decisions use ackS only.
- IDLE:
  - start=1 and wordCount!=0: memAddr<=baseAddr; remaining<=wordCount; error<=0; go to FETCH.
  - start=1 and wordCount=0: done=1 next cycle; error<=0; stay IDLE.
  - start while busy: ignored.
- FETCH (1 cycle): memAddr is stable; RAM samples it at the edge. Go to CAPTURE.
- CAPTURE (1 cycle): data<=memData; last<=(remaining==1); req<=1; go to REQ.
  - Timing: start accepted in cycle t gives req=1 visible in cycle t+3.
- REQ: data, last and req held stable. When ackS=1: req<=0; go to RELEASE.
- RELEASE: wait for ackS=0.
  - If remaining==1: done=1 for one cycle; last<=0; go to IDLE.
  - Otherwise: remaining<=remaining-1; memAddr<=memAddr+1 (mod 2^ADDR_W, so 0x3FFFF wraps to 0x00000); go to FETCH.
- active (gpioOut[26]) = busy. Data bits hold the last transmitted word after completion until the next CAPTURE.
- Timeout: a counter clears on entry to REQ and to RELEASE and increments each cycle spent there. When it reaches TIMEOUT: error<=1; req<=0; last<=0; go to IDLE; no done pulse.
- abort=1 in any non-IDLE state: next cycle req=0, last=0, state IDLE, no done, error unchanged. abort has priority over start, ack and timeout in the same cycle.
- ackS already 1 on entry to REQ (external side misbehaving): treated as a valid ack. A stuck ack is then caught by the RELEASE timeout.
- Reset mid-transfer: req drops immediately (async).

Test Plan:
- Reset: rst low mid-burst -> gpioOut=0, busy=0, memAddr=0 while low. After release, no activity until start.
- Single word: mem[0x00010]=0xABCDEF, start with base=0x10, count=1 -> memAddr=0x10 at t+1; req=1, data=0xABCDEF, last=1 at t+3. BFM acks 2 cycles later -> req drops; ack released -> done pulse, busy=0.
- Burst: count=3 at base=0x3FFFE with words 0x111111, 0x222222, 0x333333 -> addresses 0x3FFFE, 0x3FFFF, 0x00000 in order. Three handshakes with the correct data; last=1 only on the third; exactly one done.
- Zero count: start with count=0 -> done pulse next cycle, req never rises, busy stays 0.
- Timeout: TIMEOUT=16, BFM never acks -> error=1 and req=0 after 16 cycles in REQ, no done. The next start clears error.
- Abort: abort asserted while in RELEASE of word 2 of 4 -> next cycle IDLE, req=0, no done. A following start with count=1 completes normally.
